// File: rtl/au_seq_ctrl.sv
// rtl/au_seq_ctrl.sv - ADD/SUB/MUL command sequencer driving a shared 16-bit add/subtract unit
// Optional build macro AU_SEQ_ZERO_SKIP_EN: end MUL early once the remaining multiplier bits are zero.
module au_seq_ctrl #(
    parameter int WIDTH  = 16,
    parameter int ITER_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_x,
    output logic             res_z,
    output logic             res_err,
    output logic             busy,
    output logic [WIDTH-1:0] au_a,
    output logic [WIDTH-1:0] au_b,
    output logic [1:0]       au_sel,
    input  logic [WIDTH-1:0] au_x,
    input  logic             au_z
);

    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_MUL  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next;

    // r_a/r_b double as multiplicand/multiplier during MUL; they shift each iteration.
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [WIDTH-1:0]  r_acc;
    logic [ITER_W-1:0] r_cnt;
    logic              r_sub;
    logic [WIDTH-1:0]  r_res_x;
    logic              r_res_z;
    logic              r_res_err;
    logic              r_res_valid;
    logic              w_accept;
    logic              w_mul_last;

    assign w_accept  = cmd_valid && (r_state == S_IDLE);
    assign cmd_ready = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign res_x     = r_res_x;
    assign res_z     = r_res_z;
    assign res_err   = r_res_err;
    assign res_valid = r_res_valid;

`ifdef AU_SEQ_ZERO_SKIP_EN
    assign w_mul_last = ((r_b >> 1) == '0) || (r_cnt == ITER_W'(WIDTH - 1));
`else
    assign w_mul_last = (r_cnt == ITER_W'(WIDTH - 1));
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_op == OP_RSV)      w_next = S_DONE;
                    else if (cmd_op == OP_MUL) w_next = S_MUL;
                    else                       w_next = S_EXEC;
                end
            end
            S_EXEC:  w_next = S_DONE;
            S_MUL:   if (w_mul_last) w_next = S_DONE;
            S_DONE:  if (res_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        au_a   = '0;
        au_b   = '0;
        au_sel = 2'b00;
        case (r_state)
            S_EXEC: begin
                au_a   = r_a;
                au_b   = r_b;
                au_sel = {1'b0, r_sub};
            end
            S_MUL: begin
                au_a = r_acc;
                au_b = r_b[0] ? r_a : '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a         <= '0;
            r_b         <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_sub       <= 1'b0;
            r_res_x     <= '0;
            r_res_z     <= 1'b0;
            r_res_err   <= 1'b0;
            r_res_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a   <= cmd_a;
                        r_b   <= cmd_b;
                        r_sub <= (cmd_op == OP_SUB);
                        r_acc <= '0;
                        r_cnt <= '0;
                        if (cmd_op == OP_RSV) begin
                            r_res_x     <= '0;
                            r_res_z     <= 1'b1;
                            r_res_err   <= 1'b1;
                            r_res_valid <= 1'b1;
                        end
                    end
                end
                S_EXEC: begin
                    r_res_x     <= au_x;
                    r_res_z     <= au_z;
                    r_res_err   <= 1'b0;
                    r_res_valid <= 1'b1;
                end
                S_MUL: begin
                    r_acc <= au_x;
                    r_a   <= r_a << 1;
                    r_b   <= r_b >> 1;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_mul_last) begin
                        r_res_x     <= au_x;
                        r_res_z     <= au_z;
                        r_res_err   <= 1'b0;
                        r_res_valid <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (res_ready) r_res_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/au_seq_ctrl.md
Name: au_seq_ctrl

Overview:
Command sequencer that owns the shared 16-bit add/subtract arithmetic unit (AU) and drives its operand and select inputs. It accepts ADD, SUB and MUL commands over a valid/ready interface. ADD/SUB take a single AU pass; MUL runs an iterative shift-add loop through the same AU. Results come back over a valid/ready result port, so CPU-side logic gains multiply without a second adder.

Parameters:
WIDTH, 16, operand/result width; must equal AU width (16); other values unsupported.
ITER_W, 4, iteration counter width; must satisfy 2**ITER_W == WIDTH.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  block can accept a command
cmd_op  in  2  00 ADD, 01 SUB, 10 MUL, 11 reserved
cmd_a  in  WIDTH  operand A (multiplicand for MUL)
cmd_b  in  WIDTH  operand B (multiplier for MUL)
res_valid  out  1  result present
res_ready  in  1  consumer takes result
res_x  out  WIDTH  result
res_z  out  1  result == 0
res_err  out  1  reserved opcode was issued
busy  out  1  state != IDLE
au_a  out  WIDTH  to AU A input
au_b  out  WIDTH  to AU B input
au_sel  out  2  to AU sel; bit0 = 1 selects A-B; bit1 always 0
au_x  in  WIDTH  AU result, combinational from au_a/au_b/au_sel
au_z  in  1  AU zero flag

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset: state=IDLE; res_x=0, res_z=0, res_err=0, res_valid=0, busy=0, internal registers 0. cmd_ready=1 once rst deasserts.
- States: IDLE, EXEC, MUL, DONE. Outputs are registered except cmd_ready and busy, which decode from state.
- au_a/au_b/au_sel = 0 in IDLE and DONE.
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready, latch op, a, b.
  - ADD/SUB -> EXEC.
  - MUL -> MUL with acc=0, mcand=a, mplier=b, cnt=0.
  - Op 11 -> DONE with res_x=0, res_z=1, res_err=1.
- EXEC: au_a=a_q, au_b=b_q, au_sel={0, op==SUB}. At the next edge capture res_x=au_x, res_z=au_z, res_err=0, then go to DONE.
  - res_valid rises one cycle after the accept edge.
- SUB result is modulo 2^16: 3-5 = 0xFFFE. ADD carry-out is discarded.
- MUL, per cycle:
  - Drive au_a=acc, au_b = mplier[0] ? mcand : 0, au_sel=00.
  - Edge updates: acc<=au_x; mcand<=mcand<<1; mplier<=mplier>>1; cnt<=cnt+1.
  - When cnt==WIDTH-1, capture res_x=au_x, res_z=au_z and go to DONE.
  - Product is the low 16 bits of the unsigned a*b; 16 MUL cycles, so res_valid rises 16 cycles after the accept edge.
- DONE: res_valid=1, and res_x/res_z/res_err hold stable until res_ready=1 at an edge, then return to IDLE with res_valid=0.
- cmd_ready=0 in EXEC, MUL and DONE, so a new command cannot be accepted in the same cycle a result is taken. Minimum command spacing is 3 cycles for ADD/SUB.
- cmd_valid is ignored outside IDLE; the command is not lost while held.
- rst mid-operation (any state) aborts immediately to reset values; partial results are discarded and no res_valid is produced.

Optional Feature:
Macro AU_SEQ_ZERO_SKIP_EN.
- Defined: in MUL, finish when (mplier>>1)==0 or cnt==WIDTH-1, whichever comes first, capturing au_x/au_z that cycle. MUL latency = max(1, index of highest set bit of b + 1) cycles; b=0 gives 1 cycle, result 0, res_z=1.
- Undefined: MUL always takes exactly 16 cycles regardless of operands. Results are identical in both builds.

Test Plan:
- ADD a=0x1234 b=0x0001 -> res_x=0x1235, res_z=0, res_err=0; res_valid one cycle after accept; au_sel=00 during EXEC.
- SUB 0x0005-0x0005 -> 0x0000, res_z=1. SUB 0x0003-0x0005 -> 0xFFFE, res_z=0; au_sel=01 during EXEC.
- MUL 0x0003*0x0005 -> 0x000F, res_valid 16 cycles after accept (3 cycles with AU_SEQ_ZERO_SKIP_EN). MUL 0x0100*0x0100 -> 0x0000, res_z=1 (overflow truncated).
- Backpressure: hold res_ready=0 for 5 cycles after ADD completes -> res_valid and res_x stable, cmd_ready=0, second cmd_valid not accepted until the cycle after the handshake.
- Reserved op 11 -> res_err=1, res_x=0, res_z=1; the next ADD clears res_err to 0.
- Assert rst in MUL cycle 7 of 0x00FF*0x00FF -> all outputs return to reset values asynchronously, no res_valid. A fresh MUL then returns 0xFE01.
